// File: rtl/real_trace_capture.sv
// Triggered, decimating capture buffer for one signed fixed-point sample stream, with valid/ready readout.
// Optional TRACE_MINMAX_EN adds min_val/max_val tracking of the stored samples.
module real_trace_capture #(
  parameter int WIDTH    = 25,
  parameter int EXPONENT = -20,
  parameter int DEPTH    = 256,
  parameter int DECIM_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   in_val,
  input  logic                      in_valid,
  input  logic                      arm,
  input  logic signed [WIDTH-1:0]   trig_level,
  input  logic                      trig_rising,
  input  logic        [DECIM_W-1:0] decim,
  output logic signed [WIDTH-1:0]   rd_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic                      rd_last,
  output logic        [1:0]         state
`ifdef TRACE_MINMAX_EN
  ,
  output logic signed [WIDTH-1:0]   min_val,
  output logic signed [WIDTH-1:0]   max_val
`endif
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  // The block compares raw values, so the scale exponent only needs to be sane.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (EXPONENT < -256) || (EXPONENT > 256)) begin : g_bad_cfg
    $error("real_trace_capture: DEPTH must be a power of 2 >= 2 and EXPONENT within +/-256");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t                    state_r, next_s;
  logic signed [WIDTH-1:0]   mem [DEPTH];
  logic signed [WIDTH-1:0]   prev_r;
  logic                      prev_ok_r;
  logic        [AW-1:0]      wr_ptr_r;
  logic        [AW-1:0]      rd_ptr_r;
  logic        [DECIM_W-1:0] decim_cnt_r;
  logic signed [WIDTH-1:0]   rd_data_r;
  logic                      rd_valid_r;
  logic                      rd_last_r;
  logic                      rise_s, fall_s, trig_hit_s;
  logic                      we_s, first_s;
  logic        [AW-1:0]      waddr_s;

  // Level-crossing detection against the previous accepted sample.
  always_comb begin
    rise_s = (prev_r < trig_level) && (in_val >= trig_level);
    fall_s = (prev_r > trig_level) && (in_val <= trig_level);
    if (trig_rising) begin
      trig_hit_s = prev_ok_r && rise_s;
    end else begin
      trig_hit_s = prev_ok_r && fall_s;
    end
  end

  // Next-state and memory write control.
  always_comb begin
    next_s  = state_r;
    we_s    = 1'b0;
    first_s = 1'b0;
    waddr_s = {AW{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (arm) begin
          next_s = S_ARMED;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (in_valid && trig_hit_s) begin
          we_s    = 1'b1;
          first_s = 1'b1;
          next_s  = S_CAPTURE;
        end else begin
          next_s  = S_ARMED;
        end
      end
      S_CAPTURE: begin
        if (in_valid && (decim_cnt_r == decim)) begin
          we_s    = 1'b1;
          waddr_s = wr_ptr_r;
          if (wr_ptr_r == AW'(DEPTH - 1)) begin
            next_s = S_READOUT;
          end else begin
            next_s = S_CAPTURE;
          end
        end else begin
          next_s = S_CAPTURE;
        end
      end
      S_READOUT: begin
        if (rd_valid_r && rd_ready && rd_last_r) begin
          next_s = S_IDLE;
        end else begin
          next_s = S_READOUT;
        end
      end
      default: next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[waddr_s] <= in_val;
    end
  end

  // Trigger history, capture counters and the readout output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r      <= {WIDTH{1'b0}};
      prev_ok_r   <= 1'b0;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      decim_cnt_r <= {DECIM_W{1'b0}};
      rd_data_r   <= {WIDTH{1'b0}};
      rd_valid_r  <= 1'b0;
      rd_last_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (arm) begin
            prev_ok_r <= 1'b0;
          end
        end
        S_ARMED: begin
          if (in_valid) begin
            prev_r    <= in_val;
            prev_ok_r <= 1'b1;
            if (trig_hit_s) begin
              wr_ptr_r    <= AW'(1);
              rd_ptr_r    <= {AW{1'b0}};
              decim_cnt_r <= {DECIM_W{1'b0}};
            end
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            if (decim_cnt_r == decim) begin
              wr_ptr_r    <= wr_ptr_r + AW'(1);
              decim_cnt_r <= {DECIM_W{1'b0}};
            end else begin
              decim_cnt_r <= decim_cnt_r + DECIM_W'(1);
            end
          end
        end
        S_READOUT: begin
          // The output register doubles as the one-cycle memory read stage.
          if (rd_valid_r && rd_ready && rd_last_r) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
          end else if (!rd_valid_r || rd_ready) begin
            rd_data_r  <= mem[rd_ptr_r];
            rd_valid_r <= 1'b1;
            rd_last_r  <= (rd_ptr_r == AW'(DEPTH - 1));
            rd_ptr_r   <= rd_ptr_r + AW'(1);
          end
        end
        default: begin
          rd_valid_r <= 1'b0;
          rd_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign state    = state_r;
  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;

`ifdef TRACE_MINMAX_EN
  logic signed [WIDTH-1:0] min_r, max_r;

  // Extremes of the stored samples, seeded by the trigger sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_r <= {WIDTH{1'b0}};
      max_r <= {WIDTH{1'b0}};
    end else if (we_s) begin
      if (first_s) begin
        min_r <= in_val;
        max_r <= in_val;
      end else begin
        if (in_val < min_r) begin
          min_r <= in_val;
        end
        if (in_val > max_r) begin
          max_r <= in_val;
        end
      end
    end
  end

  assign min_val = min_r;
  assign max_val = max_r;
`endif

endmodule

// File: tb/tb_real_trace_capture.sv
// Directed self-checking bench for real_trace_capture (WIDTH=25, DEPTH=8; 1.0 = 1048576).
module tb_real_trace_capture;
  localparam int W  = 25;
  localparam int D  = 8;
  localparam int DW = 16;
  localparam int Q  = 262144;  // 0.25
  localparam int SINE [16] = '{0, 401273, 741455, 968758, 1048576, 968758, 741455, 401273,
                               0, -401273, -741455, -968758, -1048576, -968758, -741455, -401273};

  logic                clk = 1'b0;
  logic                rst;
  logic signed [W-1:0] in_val, trig_level, rd_data;
  logic                in_valid, arm, trig_rising, rd_valid, rd_ready, rd_last;
  logic [DW-1:0]       decim;
  logic [1:0]          state;
`ifdef TRACE_MINMAX_EN
  logic signed [W-1:0] min_val, max_val;
`endif

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] got [D];
  logic                got_last [D];
  int                  n_xfer, wait_cyc, unstable;
  logic                post_valid;
  logic [1:0]          post_state;

  always #5 clk = ~clk;

  real_trace_capture #(.WIDTH(W), .EXPONENT(-20), .DEPTH(D), .DECIM_W(DW)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_valid(in_valid), .arm(arm),
    .trig_level(trig_level), .trig_rising(trig_rising), .decim(decim),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .state(state)
`ifdef TRACE_MINMAX_EN
    , .min_val(min_val), .max_val(max_val)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [W-1:0] sample(input int mode, input int k);
    if (mode == 0) return W'(k * Q);
    return W'(SINE[k % 16]);
  endfunction

  task automatic do_arm;
    in_valid = 1'b0;
    arm = 1'b1;
    step;
    arm = 1'b0;
  endtask

  task automatic feed(input int mode, input int max_k, output bit reached);
    reached = 1'b0;
    for (int k = 0; k < max_k; k++) begin
      in_valid = 1'b1;
      in_val = sample(mode, k);
      step;
      if (state == 2'd3) begin
        reached = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Drains the readout port into got[]; toggle selects the 1,0,0,1 ready pattern.
  task automatic collect(input bit toggle);
    logic signed [W-1:0] hold_d;
    logic hold_l;
    bit stalled, seen;
    int cyc;
    n_xfer = 0; wait_cyc = 0; unstable = 0;
    stalled = 1'b0; seen = 1'b0; cyc = 0; hold_d = '0; hold_l = 1'b0;
    while (n_xfer < D && cyc < 200) begin
      rd_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled && (!rd_valid || rd_data !== hold_d || rd_last !== hold_l)) unstable++;
      if (!rd_valid && !seen) wait_cyc++;
      if (rd_valid) seen = 1'b1;
      if (rd_valid && rd_ready) begin
        got[n_xfer] = rd_data;
        got_last[n_xfer] = rd_last;
        n_xfer++;
        stalled = 1'b0;
      end else if (rd_valid) begin
        stalled = 1'b1;
        hold_d = rd_data;
        hold_l = rd_last;
      end else begin
        stalled = 1'b0;
      end
      step;
      cyc++;
    end
    rd_ready = 1'b0;
    post_valid = rd_valid;
    post_state = state;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; arm = 1'b0; rd_ready = 1'b0; in_val = '0;
    trig_level = '0; trig_rising = 1'b1; decim = '0;
    step; step;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", state); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b expected 0", rd_valid); end
    checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %0b expected 0", rd_last); end
    checks++; if (rd_data !== 25'sd0) begin errors++; $display("FAIL reset_rd_data got %0d expected 0", rd_data); end
    rst = 1'b0;
    step;
  endtask

  task automatic test_ramp_rising;
    bit reached;
    logic signed [W-1:0] exp_v;
    trig_level = 25'sd524288; trig_rising = 1'b1; decim = 16'd0;
    do_arm;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ramp_armed got %0d expected 1", state); end
    feed(0, 60, reached);
    checks++; if (!reached) begin errors++; $display("FAIL ramp_reach_readout got %0d expected 3", state); end
    collect(1'b0);
    checks++; if (n_xfer != D) begin errors++; $display("FAIL ramp_count got %0d expected %0d", n_xfer, D); end
    checks++; if (wait_cyc > 2) begin errors++; $display("FAIL ramp_first_valid got %0d expected <=2", wait_cyc); end
    for (int i = 0; i < n_xfer; i++) begin
      exp_v = W'((2 + i) * Q);
      checks++; if (got[i] !== exp_v) begin errors++; $display("FAIL ramp_data[%0d] got %0d expected %0d", i, got[i], exp_v); end
      checks++; if (got_last[i] !== (i == D - 1)) begin errors++; $display("FAIL ramp_last[%0d] got %0b expected %0b", i, got_last[i], i == D - 1); end
    end
    checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL ramp_valid_after got %0b expected 0", post_valid); end
    checks++; if (post_state !== 2'd0) begin errors++; $display("FAIL ramp_idle_after got %0d expected 0", post_state); end
  endtask

  task automatic test_flat_no_trigger;
    int bad;
    bad = 0;
    trig_level = 25'sd524288; trig_rising = 1'b0; decim = 16'd0;
    do_arm;
    for (int k = 0; k < 100; k++) begin
      in_valid = 1'b1; in_val = 25'sd524288;
      step;
      if (state !== 2'd1 || rd_valid !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL flat_bad_cycles got %0d expected 0", bad); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL flat_state got %0d expected 1", state); end
    rst = 1'b1; step; rst = 1'b0; step;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL flat_reset got %0d expected 0", state); end
  endtask

  task automatic test_decim;
    bit reached;
    logic signed [W-1:0] exp_v;
    trig_level = 25'sd524288; trig_rising = 1'b1; decim = 16'd2;
    do_arm;
    feed(0, 80, reached);
    checks++; if (!reached) begin errors++; $display("FAIL decim_reach_readout got %0d expected 3", state); end
    collect(1'b0);
    checks++; if (n_xfer != D) begin errors++; $display("FAIL decim_count got %0d expected %0d", n_xfer, D); end
    for (int i = 0; i < n_xfer; i++) begin
      exp_v = W'((2 + 3 * i) * Q);
      checks++; if (got[i] !== exp_v) begin errors++; $display("FAIL decim_data[%0d] got %0d expected %0d", i, got[i], exp_v); end
    end
    checks++; if (post_state !== 2'd0) begin errors++; $display("FAIL decim_idle_after got %0d expected 0", post_state); end
  endtask

  task automatic test_backpressure;
    bit reached;
    logic signed [W-1:0] exp_v;
    trig_level = 25'sd524288; trig_rising = 1'b1; decim = 16'd0;
    do_arm;
    feed(0, 60, reached);
    checks++; if (!reached) begin errors++; $display("FAIL bp_reach_readout got %0d expected 3", state); end
    collect(1'b1);
    checks++; if (n_xfer != D) begin errors++; $display("FAIL bp_count got %0d expected %0d", n_xfer, D); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes expected 0", unstable); end
    for (int i = 0; i < n_xfer; i++) begin
      exp_v = W'((2 + i) * Q);
      checks++; if (got[i] !== exp_v) begin errors++; $display("FAIL bp_data[%0d] got %0d expected %0d", i, got[i], exp_v); end
      checks++; if (got_last[i] !== (i == D - 1)) begin errors++; $display("FAIL bp_last[%0d] got %0b expected %0b", i, got_last[i], i == D - 1); end
    end
    checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after got %0b expected 0", post_valid); end
  endtask

  task automatic test_reset_mid_capture;
    bit reached;
    logic signed [W-1:0] exp_v;
    trig_level = 25'sd524288; trig_rising = 1'b1; decim = 16'd0;
    do_arm;
    feed(0, 5, reached);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL midrst_capturing got %0d expected 2", state); end
    rst = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d expected 0", state); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL midrst_rd_valid got %0b expected 0", rd_valid); end
    step;
    rst = 1'b0;
    step;
    do_arm;
    feed(0, 60, reached);
    checks++; if (!reached) begin errors++; $display("FAIL midrst_reach_readout got %0d expected 3", state); end
    collect(1'b0);
    checks++; if (n_xfer != D) begin errors++; $display("FAIL midrst_count got %0d expected %0d", n_xfer, D); end
    for (int i = 0; i < n_xfer; i++) begin
      exp_v = W'((2 + i) * Q);
      checks++; if (got[i] !== exp_v) begin errors++; $display("FAIL midrst_data[%0d] got %0d expected %0d", i, got[i], exp_v); end
    end
  endtask

`ifdef TRACE_MINMAX_EN
  task automatic test_minmax;
    bit reached;
    logic signed [W-1:0] exp_v, mn, mx;
    trig_level = -25'sd524288; trig_rising = 1'b0; decim = 16'd0;
    do_arm;
    feed(1, 60, reached);
    checks++; if (!reached) begin errors++; $display("FAIL mm_reach_readout got %0d expected 3", state); end
    collect(1'b0);
    checks++; if (n_xfer != D) begin errors++; $display("FAIL mm_count got %0d expected %0d", n_xfer, D); end
    mn = got[0]; mx = got[0];
    for (int i = 0; i < n_xfer; i++) begin
      exp_v = W'(SINE[(10 + i) % 16]);
      checks++; if (got[i] !== exp_v) begin errors++; $display("FAIL mm_data[%0d] got %0d expected %0d", i, got[i], exp_v); end
      if (got[i] < mn) mn = got[i];
      if (got[i] > mx) mx = got[i];
    end
    step; step;
    checks++; if (min_val !== -25'sd1048576) begin errors++; $display("FAIL mm_min got %0d expected -1048576", min_val); end
    checks++; if (max_val !== 25'sd401273) begin errors++; $display("FAIL mm_max got %0d expected 401273", max_val); end
    checks++; if (min_val !== mn || max_val !== mx) begin errors++; $display("FAIL mm_vs_read got %0d/%0d expected %0d/%0d", min_val, max_val, mn, mx); end
  endtask
`endif

  initial begin
    test_reset;
    test_ramp_rising;
    test_flat_no_trigger;
    test_decim;
    test_backpressure;
    test_reset_mid_capture;
`ifdef TRACE_MINMAX_EN
    test_minmax;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
